store_size_unit: RTL and testbench

Store-path counterpart of the load sign/zero extender in the multicycle MIPS datapath: truncates a 32-bit register value to word, halfword or byte and writes it into word-addressed memory. Sub-word stores use a read-modify-write sequence so neighbouring bytes are preserved. The unit sits between register B / ALUOut and the memory port and is started by the control FSM during the store execution step.

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/store_lane_merge.sv | 28 ++
 rtl/store_size_unit.sv | 114 +++++++++++
 tb/tb_store_size_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared store-path encodings and lane widths
package mips_mem_pkg;

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - splices truncated store data into an old memory word
import mips_mem_pkg::*;

module store_lane_merge (
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] new_data,
    input  op_e               op,
    input  logic [1:0]        lane,
    output logic [WORD_W-1:0] merged
);

    // Little-endian lanes: byte k lives at bits 8k+7:8k
    always_comb begin
        merged = old_word;
        case (op)
            OP_SW: merged = new_data;
            OP_SH: begin
                if (lane[1])
                    merged[HALF_W +: HALF_W] = new_data[HALF_W-1:0];
                else
                    merged[0 +: HALF_W] = new_data[HALF_W-1:0];
            end
            OP_SB: merged[{lane, 3'b000} +: BYTE_W] = new_data[BYTE_W-1:0];
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_size_unit.sv
// rtl/store_size_unit.sv - word/half/byte store sequencer with read-modify-write
import mips_mem_pkg::*;

module store_size_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WORD_W-1:0]  addr,
    input  logic [WORD_W-1:0]  wdata_in,
    input  logic [WORD_W-1:0]  mem_rd_data,
    output logic [WORD_W-1:0]  mem_addr,
    output logic               mem_wr,
    output logic [WORD_W-1:0]  mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    state_e            state;
    op_e               op_q;
    op_e               op_dec;
    logic [1:0]        lane_q;
    logic [WORD_W-1:0] data_q;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] merged;
    logic              bad;

    assign op_dec = op_e'(op);

    always_comb begin
        bad = (op_dec == OP_RSV)
           || (op_dec == OP_SH && addr[0])
           || (op_dec == OP_SW && addr[1:0] != 2'b00);
    end

    store_lane_merge u_merge (
        .old_word (mem_rd_data),
        .new_data (data_q),
        .op       (op_q),
        .lane     (lane_q),
        .merged   (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_SW;
            lane_q    <= 2'b00;
            data_q    <= '0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op_dec;
                        lane_q   <= addr[1:0];
                        data_q   <= wdata_in;
                        mem_addr <= {addr[WORD_W-1:2], 2'b00};
                        busy     <= 1'b1;
                        if (bad) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (op_dec == OP_SW) begin
                            state     <= ST_WRITE;
                            mem_wdata <= wdata_in;
                            mem_wr    <= 1'b1;
                        end else begin
                            state <= ST_READ;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                // Hold READ until the memory word has had MEM_LATENCY cycles to arrive
                ST_READ: begin
                    if (cnt == '0)
                        state <= ST_MERGE;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_MERGE: begin
                    mem_wdata <= merged;
                    mem_wr    <= 1'b1;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_wr <= 1'b0;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_size_unit.sv
// tb/tb_store_size_unit.sv - directed self-checking bench at MEM_LATENCY 1 and 3
module tb_store_size_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [2];
    logic        start [2];
    logic [1:0]  op [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rd [2];
    logic [31:0] maddr [2];
    logic [31:0] mwdata [2];
    logic        mwr [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gd
            store_size_unit #(.MEM_LATENCY(g == 0 ? 1 : 3)) dut (
                .clk         (clk),
                .reset       (reset[g]),
                .start       (start[g]),
                .op          (op[g]),
                .addr        (addr[g]),
                .wdata_in    (wdata[g]),
                .mem_rd_data (rd[g]),
                .mem_addr    (maddr[g]),
                .mem_wr      (mwr[g]),
                .mem_wdata   (mwdata[g]),
                .busy        (busy[g]),
                .done        (done[g]),
                .err         (err[g])
            );
        end
    endgenerate

    // Word memory with a read pipeline: data for an address is visible LAT cycles later
    logic [31:0] mem [2][16];
    logic [31:0] pipe [2][3];
    logic        load [2];
    logic [3:0]  load_idx [2];
    logic [31:0] load_word [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load[k])
                mem[k][load_idx[k]] <= load_word[k];
            else if (mwr[k])
                mem[k][maddr[k][5:2]] <= mwdata[k];
            pipe[k][0] <= mem[k][maddr[k][5:2]];
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign rd[0] = pipe[0][0];
    assign rd[1] = pipe[1][2];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] d, input logic [31:0] old);
        int sh;
        logic [31:0] m;
        case (o)
            2'd0: return d;
            2'd1: begin
                sh = a[1] * 16;
                m  = 32'h0000_FFFF << sh;
                return (old & ~m) | ((d & 32'h0000_FFFF) << sh);
            end
            2'd2: begin
                sh = a[1:0] * 8;
                m  = 32'h0000_00FF << sh;
                return (old & ~m) | ((d & 32'h0000_00FF) << sh);
            end
            default: return old;
        endcase
    endfunction

    function automatic bit model_err(input logic [1:0] o, input logic [31:0] a);
        return (o == 2'd3) || (o == 2'd1 && a[0]) || (o == 2'd0 && a[1:0] != 2'd0);
    endfunction

    // Expected timeline per instance, counted in cycles after the start cycle
    int          e_done [2];
    int          e_wr [2];
    int          e_abort [2];
    int          e_last [2];
    logic [31:0] e_word [2];
    logic [31:0] e_addr [2];
    logic        e_err [2];
    int          arm_id [2] = '{0, 0};
    int          seen_id [2] = '{0, 0};
    int          n [2] = '{0, 0};
    bit          active [2] = '{1'b0, 1'b0};
    int          wr_cnt [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit aborted;
            bit in_op;
            if (mwr[k]) wr_cnt[k]++;
            if (done[k]) done_cnt[k]++;
            if (arm_id[k] != seen_id[k]) begin
                seen_id[k] = arm_id[k];
                active[k]  = 1'b1;
                n[k]       = 0;
            end
            if (active[k]) begin
                aborted = (e_abort[k] >= 0) && (n[k] >= e_abort[k]);
                in_op   = !aborted && n[k] >= 1 && n[k] <= e_done[k];
                chk("busy", k, busy[k], in_op);
                chk("mem_wr", k, mwr[k], !aborted && n[k] == e_wr[k]);
                chk("done", k, done[k], !aborted && n[k] == e_done[k]);
                if (in_op) chk("mem_addr", k, maddr[k], e_addr[k]);
                if (!aborted && n[k] == e_wr[k]) chk("mem_wdata", k, mwdata[k], e_word[k]);
                if (!aborted && n[k] == e_done[k]) chk("err", k, err[k], e_err[k]);
                if (aborted) begin
                    chk("abort_addr", k, maddr[k], 32'h0);
                    chk("abort_wdata", k, mwdata[k], 32'h0);
                    chk("abort_err", k, err[k], 32'h0);
                end
                if (n[k] == e_last[k]) active[k] = 1'b0;
                else n[k]++;
            end
        end
    end

    task automatic run(input int k, input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] old, input int p1, input int p2, input int ab);
        int lat;
        int w0;
        int d0;
        logic [3:0] idx;
        lat = (k == 0) ? 1 : 3;
        idx = a[5:2];
        @(posedge clk); #1;
        load[k] = 1'b1; load_idx[k] = idx; load_word[k] = old;
        @(posedge clk); #1;
        load[k] = 1'b0;
        e_err[k]   = model_err(o, a);
        e_word[k]  = model_word(o, a, d, old);
        e_addr[k]  = {a[31:2], 2'b00};
        e_done[k]  = e_err[k] ? 1 : (o == 2'd0 ? 2 : lat + 3);
        e_wr[k]    = e_err[k] ? -1 : (o == 2'd0 ? 1 : lat + 2);
        e_abort[k] = ab;
        e_last[k]  = (ab >= 0) ? ab + 2 : e_done[k] + 2;
        w0 = wr_cnt[k];
        d0 = done_cnt[k];
        start[k] = 1'b1; op[k] = o; addr[k] = a; wdata[k] = d;
        arm_id[k]++;
        for (int m = 1; m <= e_last[k]; m++) begin
            @(posedge clk); #1;
            start[k] = (m == p1 || m == p2);
            op[k] = 2'd0; addr[k] = 32'h40; wdata[k] = 32'h1234_5678;
            if (m == ab) reset[k] = 1'b1;
            if (m == ab + 1) reset[k] = 1'b0;
        end
        @(posedge clk); #1;
        start[k] = 1'b0;
        @(negedge clk);
        chk("complete", k, active[k], 32'h0);
        chk("write_count", k, wr_cnt[k] - w0, (e_err[k] || ab >= 0) ? 1'b0 : 1'b1);
        chk("done_count", k, done_cnt[k] - d0, (ab >= 0) ? 1'b0 : 1'b1);
        chk("mem_word", k, mem[k][idx], (!e_err[k] && ab < 0) ? e_word[k] : old);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; start[k] = 1'b0; op[k] = 2'd0; addr[k] = '0; wdata[k] = '0;
            load[k] = 1'b0; load_idx[k] = '0; load_word[k] = '0; e_abort[k] = -1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, busy[k], 32'h0);
            chk("rst_done", k, done[k], 32'h0);
            chk("rst_err", k, err[k], 32'h0);
            chk("rst_wr", k, mwr[k], 32'h0);
            chk("rst_addr", k, maddr[k], 32'h0);
            chk("rst_wdata", k, mwdata[k], 32'h0);
        end
        @(posedge clk); #1;
        reset[0] = 1'b0; reset[1] = 1'b0;

        chk("pin_sb_model", 0, model_word(2'd2, 32'h13, 32'hFFFF_FFAB, 32'h1122_3344), 32'hAB22_3344);
        chk("pin_sh_model", 0, model_word(2'd1, 32'h06, 32'h0001_8000, 32'hAAAA_BBBB), 32'h8000_BBBB);

        run(0, 2'd0, 32'h10, 32'hDEAD_BEEF, 32'h0, -1, -1, -1);
        chk("pin_sw_mem", 0, mem[0][4], 32'hDEAD_BEEF);
        run(0, 2'd2, 32'h13, 32'hFFFF_FFAB, 32'h1122_3344, -1, -1, -1);
        chk("pin_sb_mem", 0, mem[0][4], 32'hAB22_3344);
        chk("pin_sb_done", 0, e_done[0], 32'd4);
        run(0, 2'd1, 32'h06, 32'h0001_8000, 32'hAAAA_BBBB, -1, -1, -1);
        chk("pin_sh_mem", 0, mem[0][1], 32'h8000_BBBB);
        run(0, 2'd1, 32'h05, 32'h1111_2222, 32'h5555_5555, -1, -1, -1);
        run(0, 2'd0, 32'h02, 32'h1111_2222, 32'h6666_6666, -1, -1, -1);
        run(0, 2'd3, 32'h08, 32'h1111_2222, 32'h7777_7777, -1, -1, -1);
        run(0, 2'd2, 32'h20, 32'h0000_00C1, 32'h0102_0304, -1, -1, -1);
        run(0, 2'd2, 32'h21, 32'h0000_00D2, 32'hFFFF_FFFF, -1, -1, -1);
        chk("pin_sb1_mem", 0, mem[0][8], 32'hFFFF_D2FF);
        run(0, 2'd2, 32'h2A, 32'hABCD_EF5A, 32'h0000_0000, -1, -1, -1);
        run(0, 2'd1, 32'h24, 32'hFFFF_1234, 32'h0000_0000, -1, -1, -1);
        chk("pin_sh0_mem", 0, mem[0][9], 32'h0000_1234);

        run(1, 2'd1, 32'h06, 32'h0001_8000, 32'hAAAA_BBBB, -1, -1, -1);
        chk("pin_sh_done3", 1, e_done[1], 32'd6);
        chk("pin_sh_mem3", 1, mem[1][1], 32'h8000_BBBB);
        run(1, 2'd2, 32'h0D, 32'h0000_00EE, 32'h1122_3344, 2, 6, -1);
        chk("pin_ignore_mem", 1, mem[1][3], 32'h1122_EE44);
        run(1, 2'd1, 32'h0A, 32'h0000_BEEF, 32'h0123_4567, -1, -1, 5);
        run(1, 2'd2, 32'h0F, 32'h0000_0077, 32'h0123_4567, -1, -1, -1);
        chk("pin_after_abort", 1, mem[1][3], 32'h7723_4567);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
